// File: rtl/rom_arbiter_if.sv
// Bus between the ROM arbiter, its two requesters and the shared ROM.
// slave  : the arbiter's view (takes requests and ROM replies, drives ready/data and ROM strobes).
// master : the environment's view (requesters plus ROM).
interface rom_arbiter_if #(
    parameter int size_addr = 8
);
    // Port 0: instruction fetch
    logic                 req0;
    logic [size_addr-1:0] addr0;
    logic                 ready0;
    logic [15:0]          data0;
    // Port 1: data load
    logic                 req1;
    logic [size_addr-1:0] addr1;
    logic                 ready1;
    logic [15:0]          data1;
    // Shared ROM
    logic                 rom_read;
    logic [size_addr-1:0] rom_address;
    logic                 rom_ready;
    logic [15:0]          rom_data;

    modport slave (
        input  req0, addr0, req1, addr1, rom_ready, rom_data,
        output ready0, data0, ready1, data1, rom_read, rom_address
    );

    modport master (
        output req0, addr0, req1, addr1, rom_ready, rom_data,
        input  ready0, data0, ready1, data1, rom_read, rom_address
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single registered-read ROM.
// Each access runs IDLE -> ISSUE -> WAIT -> RESP; the word is latched into the
// granted port's data register and a one-cycle ready pulse is returned.
// Build option: define ROM_ARB_ROUND_ROBIN_EN to alternate grants under
// contention; otherwise port 0 wins every tie.
module rom_arbiter #(
    parameter int size_addr = 8
) (
    input  logic         clk,
    input  logic         reset,
    rom_arbiter_if.slave bus
);

`ifdef ROM_ARB_ROUND_ROBIN_EN
    localparam bit round_robin = 1'b1;
`else
    localparam bit round_robin = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 gnt;          // port owning the access in flight
    logic                 last;         // port served most recently
    logic                 win;          // port that would be granted now
    logic                 rom_read_nxt;
    logic                 ready0_nxt;
    logic                 ready1_nxt;
    logic                 rom_read_q;
    logic                 ready0_q;
    logic                 ready1_q;
    logic [size_addr-1:0] rom_address_q;
    logic [15:0]          data0_q;
    logic [15:0]          data1_q;

    // Pick a winner among the ports requesting right now
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        win = 1'b0;
        if (bus.req0 && bus.req1) begin
            win = round_robin ? ~last : 1'b0;
        end else if (bus.req1) begin
            win = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; WAIT has no timeout and lasts until the ROM answers
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (bus.req0 || bus.req1) next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (bus.rom_ready) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so the strobes come straight from flops
    always_comb begin
        rom_read_nxt = (next_state == S_ISSUE);
        ready0_nxt   = (next_state == S_RESP) && !gnt;
        ready1_nxt   = (next_state == S_RESP) &&  gnt;
    end

    // Registered outputs, grant capture and per-port data latches
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_read_q    <= 1'b0;
            ready0_q      <= 1'b0;
            ready1_q      <= 1'b0;
            rom_address_q <= '0;
            data0_q       <= '0;
            data1_q       <= '0;
            gnt           <= 1'b0;
            last          <= 1'b1;
        end else begin
            rom_read_q <= rom_read_nxt;
            ready0_q   <= ready0_nxt;
            ready1_q   <= ready1_nxt;
            // Address is frozen at grant; later requester address changes are ignored
            if (state == S_IDLE && (bus.req0 || bus.req1)) begin
                gnt           <= win;
                rom_address_q <= win ? bus.addr1 : bus.addr0;
            end
            // Only the granted port's register moves; rom_ready outside WAIT is ignored
            if (state == S_WAIT && bus.rom_ready) begin
                if (gnt) begin
                    data1_q <= bus.rom_data;
                end else begin
                    data0_q <= bus.rom_data;
                end
            end
            if (state == S_RESP) begin
                last <= gnt;
            end
        end
    end

    assign bus.rom_read    = rom_read_q;
    assign bus.rom_address = rom_address_q;
    assign bus.ready0      = ready0_q;
    assign bus.ready1      = ready1_q;
    assign bus.data0       = data0_q;
    assign bus.data1       = data1_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios followed by randomized
// request traffic compared against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_rom_arbiter;

    localparam int size_addr = 8;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    localparam bit rr = 1'b1;
`else
    localparam bit rr = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rom_arbiter_if #(.size_addr(size_addr)) bus ();

    rom_arbiter #(.size_addr(size_addr)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ROM model: registered read, optional extra response delay, injectable stray pulse
    logic [15:0] mem [256];
    int          rom_delay   = 0;
    bit          inject      = 1'b0;
    logic        rom_ready_r = 1'b0;
    logic [15:0] rom_data_r  = '0;
    bit          pend        = 1'b0;
    int          cnt         = 0;
    logic [7:0]  paddr       = '0;

    assign bus.rom_ready = rom_ready_r;
    assign bus.rom_data  = rom_data_r;

    // ROM answers one cycle after the read strobe, or rom_delay cycles later than that
    always @(posedge clk) begin
        rom_ready_r <= 1'b0;
        if (inject) begin
            rom_ready_r <= 1'b1;
            rom_data_r  <= 16'hDEAD;
        end else if (bus.rom_read) begin
            if (rom_delay == 0) begin
                rom_ready_r <= 1'b1;
                rom_data_r  <= mem[bus.rom_address];
            end else begin
                pend  <= 1'b1;
                cnt   <= rom_delay;
                paddr <= bus.rom_address;
            end
        end else if (pend) begin
            if (cnt == 1) begin
                rom_ready_r <= 1'b1;
                rom_data_r  <= mem[paddr];
                pend        <= 1'b0;
            end
            cnt <= cnt - 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference grant rule: who wins given the outstanding requests and the last served port
    function automatic int pick(input bit o0, input bit o1, input int last_served);
        if (o0 && o1) return rr ? (last_served == 0 ? 1 : 0) : 0;
        return o0 ? 0 : 1;
    endfunction

    // Wait (bounded) for any ready pulse; n counts negedges until it is seen
    task automatic wait_any(input int budget, output int n, output int port, output bit seen);
        n    = 0;
        port = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.ready0 || bus.ready1) begin
                seen = 1'b1;
                port = bus.ready1 ? 1 : 0;
            end
        end
        check("ready_seen", 32'(seen), 32'd1);
    endtask

    // The two ready pulses must never coincide
    always @(negedge clk) begin
        if (!reset && (bus.ready0 || bus.ready1))
            check("ready_exclusive", 32'(bus.ready0 & bus.ready1), 32'd0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          p;
        bit          seen;
        int          last_m;
        int          exp_p;
        bit          seen_late;
        bit          o0;
        bit          o1;
        bit          from_resp;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [15:0] hd0;
        logic [15:0] hd1;

        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[1] = 16'h1111;
        mem[2] = 16'h1234;
        mem[3] = 16'hBEEF;
        mem[5] = 16'hA5C3;
        mem[6] = 16'h0606;
        mem[7] = 16'h7777;
        mem[9] = 16'h9999;

        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;

        // Power-on reset
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_ready0", 32'(bus.ready0), 32'd0);
        check("rst_ready1", 32'(bus.ready1), 32'd0);
        check("rst_rom_read", 32'(bus.rom_read), 32'd0);
        check("rst_rom_address", 32'(bus.rom_address), 32'd0);
        check("rst_data0", 32'(bus.data0), 32'd0);
        check("rst_data1", 32'(bus.data1), 32'd0);

        // Single port-0 read of ROM[5]: strobe one cycle after grant, ready three after
        @(negedge clk);
        bus.addr0 = 8'h05;
        bus.req0  = 1'b1;
        @(negedge clk);
        check("t2_rom_read", 32'(bus.rom_read), 32'd1);
        check("t2_rom_address", 32'(bus.rom_address), 32'h05);
        @(negedge clk);
        check("t2_rom_read_wait", 32'(bus.rom_read), 32'd0);
        check("t2_ready0_early", 32'(bus.ready0), 32'd0);
        @(negedge clk);
        check("t2_ready0", 32'(bus.ready0), 32'd1);
        check("t2_data0", 32'(bus.data0), 32'hA5C3);
        bus.req0 = 1'b0;
        @(negedge clk);
        check("t2_ready0_pulse", 32'(bus.ready0), 32'd0);
        check("t2_data0_held", 32'(bus.data0), 32'hA5C3);

        // Reset held two cycles mid-WAIT drops the access; late and stray rom_ready ignored
        rom_delay = 3;
        bus.addr0 = 8'h07;
        bus.req0  = 1'b1;
        @(negedge clk);
        bus.req0 = 1'b0;
        @(negedge clk);
        check("t1_no_ready_in_wait", 32'(bus.ready0), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t1_ready0", 32'(bus.ready0), 32'd0);
        check("t1_ready1", 32'(bus.ready1), 32'd0);
        check("t1_rom_read", 32'(bus.rom_read), 32'd0);
        check("t1_data0", 32'(bus.data0), 32'd0);
        check("t1_data1", 32'(bus.data1), 32'd0);
        reset     = 1'b0;
        seen_late = 1'b0;
        for (int i = 0; i < 8; i++) begin
            inject = (i == 3);
            @(negedge clk);
            if (bus.rom_ready) seen_late = 1'b1;
            check("t1_quiet", {bus.ready0, bus.ready1, 30'd0} | 32'(bus.data0) | 32'(bus.data1), 32'd0);
        end
        inject = 1'b0;
        check("t1_late_rom_ready_happened", 32'(seen_late), 32'd1);
        rom_delay = 0;
        last_m    = 1;

        // Continuous contention: grant order follows the tie rule, one access every 4 cycles
        bus.addr0 = 8'h01;
        bus.addr1 = 8'h02;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_p = pick(1'b1, 1'b1, last_m);
            wait_any(12, n, p, seen);
            check("t3_grant", 32'(p), 32'(exp_p));
            check("t3_gap", 32'(n), (k == 0) ? 32'd3 : 32'd4);
            if (p == 0) check("t3_data0", 32'(bus.data0), 32'h1111);
            else        check("t3_data1", 32'(bus.data1), 32'h1234);
            last_m = exp_p;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);

        // Port 1 reads ROM[2], then port 0 reads ROM[3]; data1 must hold throughout
        bus.addr1 = 8'h02;
        bus.req1  = 1'b1;
        wait_any(12, n, p, seen);
        check("t4_port1", 32'(p), 32'd1);
        check("t4_data1", 32'(bus.data1), 32'h1234);
        bus.req1 = 1'b0;
        last_m   = 1;
        @(negedge clk);
        bus.addr0 = 8'h03;
        bus.req0  = 1'b1;
        n         = 0;
        while (!bus.ready0 && n < 12) begin
            @(negedge clk);
            n++;
            check("t4_data1_held", 32'(bus.data1), 32'h1234);
        end
        check("t4_ready0", 32'(bus.ready0), 32'd1);
        check("t4_data0", 32'(bus.data0), 32'hBEEF);
        bus.req0 = 1'b0;
        last_m   = 0;
        @(negedge clk);
        check("t4_data1_after", 32'(bus.data1), 32'h1234);

        // Address change after grant does not affect the access
        bus.addr0 = 8'h05;
        bus.req0  = 1'b1;
        @(negedge clk);
        check("t5_rom_address", 32'(bus.rom_address), 32'h05);
        bus.addr0 = 8'h06;
        wait_any(12, n, p, seen);
        check("t5_port", 32'(p), 32'd0);
        check("t5_data0", 32'(bus.data0), 32'hA5C3);
        check("t5_rom_address_held", 32'(bus.rom_address), 32'h05);
        bus.req0 = 1'b0;
        @(negedge clk);

        // Slow ROM: WAIT holds until rom_ready, ready0 follows one cycle later
        rom_delay = 3;
        bus.addr0 = 8'h09;
        bus.req0  = 1'b1;
        wait_any(16, n, p, seen);
        check("t6_latency", 32'(n), 32'd6);
        check("t6_port", 32'(p), 32'd0);
        check("t6_data0", 32'(bus.data0), 32'h9999);
        bus.req0  = 1'b0;
        rom_delay = 0;
        @(negedge clk);

        // Randomized traffic against the transaction-level model
        o0        = 1'b0;
        o1        = 1'b0;
        a0        = '0;
        a1        = '0;
        hd0       = 16'h9999;
        hd1       = 16'h1234;
        from_resp = 1'b0;
        for (int it = 0; it < 200; it++) begin
            if (!o0 && $urandom_range(0, 2) != 0) begin
                o0 = 1'b1; a0 = 8'($urandom); bus.addr0 = a0; bus.req0 = 1'b1;
            end
            if (!o1 && $urandom_range(0, 2) != 0) begin
                o1 = 1'b1; a1 = 8'($urandom); bus.addr1 = a1; bus.req1 = 1'b1;
            end
            if (!o0 && !o1) begin
                @(negedge clk);
                from_resp = 1'b0;
                continue;
            end
            rom_delay = $urandom_range(0, 2);
            exp_p     = pick(o0, o1, last_m);
            wait_any(16, n, p, seen);
            check("rnd_port", 32'(p), 32'(exp_p));
            check("rnd_latency", 32'(n), 32'((from_resp ? 4 : 3) + rom_delay));
            if (exp_p == 0) hd0 = mem[a0];
            else            hd1 = mem[a1];
            check("rnd_data0", 32'(bus.data0), 32'(hd0));
            check("rnd_data1", 32'(bus.data1), 32'(hd1));
            if (exp_p == 0) begin
                o0 = 1'b0; bus.req0 = 1'b0;
            end else begin
                o1 = 1'b0; bus.req1 = 1'b0;
            end
            last_m    = exp_p;
            from_resp = 1'b1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
